// File: rtl/nrzi_stuff_enc.sv
// NRZI line encoder with bit stuffing: a 0 toggles the line, a 1 holds it, and
// a stuffed 0 is forced after RUN_LEN consecutive 1s, costing one input bubble.
module nrzi_stuff_enc #(
    parameter int   RUN_LEN  = 6,
    parameter logic IDLE_LVL = 1'b1,
    parameter int   COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               inb,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stuff_en,
    input  logic               bypass,
    output logic               outb,
    output logic               out_valid,
    output logic [COUNT_W-1:0] stuff_cnt
);

    localparam int               RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    typedef enum logic {
        S_DATA,
        S_STUFF
    } state_t;

    state_t             state, state_nx;
    logic               level, level_nx;
    logic               valid_nx;
    logic [RUN_W-1:0]   run, run_nx, run_inc;
    logic [COUNT_W-1:0] cnt_nx;
    logic               accept;

    assign in_ready = (state == S_DATA);
    assign accept   = in_valid && in_ready;
    assign outb     = level;
    assign run_inc  = (run == RUN_MAX) ? run : run + 1'b1;

    // NOTE: every signal gets its default first, so no path through the case
    // statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        level_nx = level;
        run_nx   = run;
        cnt_nx   = stuff_cnt;
        valid_nx = 1'b0;
        case (state)
            S_STUFF: begin
                level_nx = ~level;
                run_nx   = '0;
                valid_nx = 1'b1;
                state_nx = S_DATA;
                if (stuff_cnt != '1) cnt_nx = stuff_cnt + 1'b1;
            end
            default: begin
                if (accept) begin
                    valid_nx = 1'b1;
                    if (bypass) begin
                        level_nx = inb;
                        run_nx   = '0;
                    end else if (!inb) begin
                        level_nx = ~level;
                        run_nx   = '0;
                    end else begin
                        run_nx = run_inc;
                        // A run saturated while stuffing was off is stuffed as
                        // soon as stuffing is re-enabled, keeping the line lively.
                        if (stuff_en && run_inc == RUN_MAX) state_nx = S_STUFF;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state     <= S_DATA;
            level     <= IDLE_LVL;
            run       <= '0;
            out_valid <= 1'b0;
            stuff_cnt <= '0;
        end else begin
            state     <= state_nx;
            level     <= level_nx;
            run       <= run_nx;
            out_valid <= valid_nx;
            stuff_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_nrzi_stuff_enc.sv
// Directed bench for nrzi_stuff_enc: a default instance plus a COUNT_W=2
// instance driven in parallel to exercise counter saturation.
module tb_nrzi_stuff_enc;

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic       inb = 1'b0;
    logic       in_valid = 1'b0;
    logic       stuff_en = 1'b1;
    logic       bypass = 1'b0;
    logic       in_ready, outb, out_valid;
    logic [7:0] stuff_cnt;
    logic       in_ready_s, outb_s, out_valid_s;
    logic [1:0] stuff_cnt_s;

    nrzi_stuff_enc u_dut (
        .clk(clk), .rst_L(rst_L), .inb(inb), .in_valid(in_valid), .in_ready(in_ready),
        .stuff_en(stuff_en), .bypass(bypass), .outb(outb), .out_valid(out_valid),
        .stuff_cnt(stuff_cnt)
    );

    nrzi_stuff_enc #(.COUNT_W(2)) u_sat (
        .clk(clk), .rst_L(rst_L), .inb(inb), .in_valid(in_valid), .in_ready(in_ready_s),
        .stuff_en(stuff_en), .bypass(bypass), .outb(outb_s), .out_valid(out_valid_s),
        .stuff_cnt(stuff_cnt_s)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] s_val;
    int          s_len;
    int          bubbles;
    int          lat_err;
    logic        idle_valid;
    logic        idle_outb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_L    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_L = 1'b1;
    endtask

    task automatic record();
        if (out_valid) begin
            s_val = {s_val[62:0], outb};
            s_len++;
        end
    endtask

    // Sends n bits (v[n-1] first), retrying while the encoder bubbles; the
    // optional idle cycle afterwards captures a trailing stuff bit or idle state.
    task automatic run_seq(input logic [63:0] v, input int n, input bit flush);
        logic acc;
        bit   done;
        s_val   = '0;
        s_len   = 0;
        bubbles = 0;
        lat_err = 0;
        for (int i = 0; i < n; i++) begin
            done = 1'b0;
            for (int t = 0; t < 4 && !done; t++) begin
                in_valid = 1'b1;
                inb      = v[n-1-i];
                acc      = in_ready;
                if (!acc) bubbles++;
                tick();
                record();
                if (acc) begin
                    done = 1'b1;
                    if (!out_valid) lat_err++;
                end
            end
            if (!done) check("accept_timeout", 64'(done), 64'd1);
        end
        in_valid = 1'b0;
        if (flush) begin
            tick();
            idle_valid = out_valid;
            idle_outb  = outb;
            record();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_outb", 64'(outb), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stuff_cnt", 64'(stuff_cnt), 64'd0);

        // Plain NRZI
        run_seq(64'b11001, 5, 1'b1);
        check("nrzi_stream", s_val, 64'b11011);
        check("nrzi_len", 64'(s_len), 64'd5);
        check("nrzi_latency", 64'(lat_err), 64'd0);
        check("nrzi_bubbles", 64'(bubbles), 64'd0);
        check("nrzi_idle_valid", 64'(idle_valid), 64'd0);
        check("nrzi_idle_outb", 64'(idle_outb), 64'd1);

        // Seven 1s: stuff after the sixth
        do_reset();
        run_seq(64'b1111111, 7, 1'b1);
        check("stuff_stream", s_val, 64'b11111100);
        check("stuff_len", 64'(s_len), 64'd8);
        check("stuff_bubbles", 64'(bubbles), 64'd1);
        check("stuff_cnt_1", 64'(stuff_cnt), 64'd1);
        check("stuff_idle_valid", 64'(idle_valid), 64'd0);

        // Five 1s, a 0, five 1s: never reaches the run limit
        do_reset();
        run_seq(64'b11111011111, 11, 1'b1);
        check("nostuff_stream", s_val, 64'b11111000000);
        check("nostuff_len", 64'(s_len), 64'd11);
        check("nostuff_bubbles", 64'(bubbles), 64'd0);
        check("nostuff_cnt", 64'(stuff_cnt), 64'd0);

        // Stuffing disabled, ten 1s
        do_reset();
        stuff_en = 1'b0;
        run_seq(64'h3FF, 10, 1'b1);
        check("dis_stream", s_val, 64'h3FF);
        check("dis_len", 64'(s_len), 64'd10);
        check("dis_bubbles", 64'(bubbles), 64'd0);
        check("dis_cnt", 64'(stuff_cnt), 64'd0);
        stuff_en = 1'b1;

        // Bypass: line follows input, no stuffing
        do_reset();
        bypass = 1'b1;
        run_seq(64'b101111111, 9, 1'b1);
        check("byp_stream", s_val, 64'b101111111);
        check("byp_len", 64'(s_len), 64'd9);
        check("byp_bubbles", 64'(bubbles), 64'd0);
        check("byp_cnt", 64'(stuff_cnt), 64'd0);

        // Bypass dropped mid-stream: next 0 toggles from the bypassed level 1
        bypass = 1'b0;
        run_seq(64'b0, 1, 1'b1);
        check("byp_exit_stream", s_val, 64'b0);
        check("byp_exit_cnt", 64'(stuff_cnt), 64'd0);

        // Reset during a pending stuff: line was 0, stuff discarded
        do_reset();
        run_seq(64'b0111111, 7, 1'b0);
        check("pend_in_ready", 64'(in_ready), 64'd0);
        check("pend_outb", 64'(outb), 64'd0);
        rst_L = 1'b0;
        tick();
        rst_L = 1'b1;
        check("rststuff_in_ready", 64'(in_ready), 64'd1);
        check("rststuff_outb", 64'(outb), 64'd1);
        check("rststuff_out_valid", 64'(out_valid), 64'd0);
        check("rststuff_cnt", 64'(stuff_cnt), 64'd0);
        tick();
        check("rststuff_no_emit", 64'(out_valid), 64'd0);
        check("rststuff_cnt_after", 64'(stuff_cnt), 64'd0);

        // Thirty 1s: five stuff events, the last emitted on the idle cycle
        do_reset();
        run_seq(64'h3FFF_FFFF, 30, 1'b1);
        check("sat_stream", s_val,
              {29'd0, 7'b1111110, 7'b0000001, 7'b1111110, 7'b0000001, 7'b1111110});
        check("sat_len", 64'(s_len), 64'd35);
        check("sat_bubbles", 64'(bubbles), 64'd4);
        check("sat_cnt_wide", 64'(stuff_cnt), 64'd5);
        check("sat_cnt_narrow", 64'(stuff_cnt_s), 64'd3);
        tick();
        check("sat_narrow_in_ready", 64'(in_ready_s), 64'd1);
        check("sat_narrow_out_valid", 64'(out_valid_s), 64'd0);
        check("sat_narrow_outb", 64'(outb_s), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
